// File: rtl/tb_portb_rd_ctrl_pkg.sv
// Shared types for the temp-buffer port-B read sequencer: selector codes,
// direction codes, FSM encoding and default widths.
package tb_portb_rd_ctrl_pkg;

    localparam int unsigned TbAwDef      = 10;
    localparam int unsigned SeqCntDwDef  = 5;
    localparam int unsigned SelDwDef     = 5;
    localparam int unsigned RdLatDef     = 2;

    // Target code carried in TB_doutb_sel[4:2].
    typedef enum logic [2:0] {
        TBb_IDLE             = 3'b000,
        TBb_B                = 3'b001,
        TBb_B_cache_IDLE     = 3'b100,
        TBb_H_lv_H_transpose = 3'b101,
        TBb_cov_HT_transpose = 3'b110,
        TBb_B_cache_inv      = 3'b111
    } tbb_tgt_e;

    // Direction / sub-mode carried in TB_doutb_sel[1:0].
    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_POS  = 2'b01,
        DIR_NEG  = 2'b10,
        DIR_NEW  = 2'b11
    } tbb_dir_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StIssue = 1'b1
    } rd_state_e;

    function automatic logic [4:0] tbb_sel(tbb_tgt_e tgt, tbb_dir_e dir);
        return {tgt, dir};
    endfunction

endpackage

// File: rtl/tb_portb_rd_ctrl_if.sv
// Command channel and port-B / mapper-side outputs of the read sequencer.
interface tb_portb_rd_ctrl_if #(
    parameter int unsigned TB_AW           = 10,
    parameter int unsigned SEQ_CNT_DW      = 5,
    parameter int unsigned TB_DOUTB_SEL_DW = 5
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [TB_DOUTB_SEL_DW-1:0] cmd_sel;
    logic                       cmd_l_k_0;
    logic [TB_AW-1:0]           cmd_base_addr;
    logic                       cmd_addr_dec;
    logic [SEQ_CNT_DW-1:0]      cmd_len;
    logic [SEQ_CNT_DW-1:0]      cmd_seq_start;

    logic                       TB_enb;
    logic [TB_AW-1:0]           TB_addrb;
    logic [TB_DOUTB_SEL_DW-1:0] TB_doutb_sel;
    logic                       l_k_0;
    logic [SEQ_CNT_DW-1:0]      seq_cnt_out;
    logic                       busy;
    logic                       done;

    modport master (
        output cmd_valid, cmd_sel, cmd_l_k_0, cmd_base_addr, cmd_addr_dec, cmd_len,
               cmd_seq_start,
        input  cmd_ready, TB_enb, TB_addrb, TB_doutb_sel, l_k_0, seq_cnt_out, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_l_k_0, cmd_base_addr, cmd_addr_dec, cmd_len,
               cmd_seq_start,
        output cmd_ready, TB_enb, TB_addrb, TB_doutb_sel, l_k_0, seq_cnt_out, busy, done
    );

endinterface

// File: rtl/tb_rd_align_shreg.sv
// Fixed-depth shift register with synchronous clear; the MSB of each word is
// its valid flag and is OR-reduced across all stages.
module tb_rd_align_shreg #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q,
    output logic          o_valid_any
);

    logic [DW-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

    always_comb begin
        o_valid_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_valid_any = o_valid_any | r_stage[i][DW-1];
        end
    end

endmodule

// File: rtl/tb_portb_rd_ctrl.sv
// Temp-buffer port-B read sequencer: issues cmd_len consecutive rows and delays
// selector / l_k_0 / sequence count by RD_LAT so they meet the matching TB_doutb word.
module tb_portb_rd_ctrl
    import tb_portb_rd_ctrl_pkg::*;
#(
    parameter int unsigned TB_AW           = TbAwDef,
    parameter int unsigned SEQ_CNT_DW      = SeqCntDwDef,
    parameter int unsigned TB_DOUTB_SEL_DW = SelDwDef,
    parameter int unsigned RD_LAT          = RdLatDef
) (
    input  logic               clk,
    input  logic               sys_rst,
    tb_portb_rd_ctrl_if.slave  bus
);

    // Pipe word layout, MSB first: {valid, last, sel, l_k_0, seq}.
    localparam int unsigned PipeDw = 2 + TB_DOUTB_SEL_DW + 1 + SEQ_CNT_DW;

    rd_state_e                  r_state;
    logic                       r_ready;
    logic                       r_enb;
    logic [TB_AW-1:0]           r_addrb;
    logic [SEQ_CNT_DW-1:0]      r_k;
    logic [SEQ_CNT_DW-1:0]      r_len;
    logic [SEQ_CNT_DW-1:0]      r_seq;
    logic                       r_dec;
    logic [TB_DOUTB_SEL_DW-1:0] r_sel;
    logic                       r_lk0;

    logic                       w_last;
    logic                       w_accept;
    logic                       w_load;
    logic [SEQ_CNT_DW-1:0]      w_k_nxt;
    logic [PipeDw-1:0]          w_pipe_d;
    logic [PipeDw-1:0]          w_pipe_q;
    logic                       w_pipe_any;

    assign w_last   = (r_k == r_len - SEQ_CNT_DW'(1));
    assign w_k_nxt  = r_k + SEQ_CNT_DW'(1);
    // cmd_ready is only ever high in IDLE or on the last issue row.
    assign w_accept = bus.cmd_valid & r_ready;
    assign w_load   = w_accept & (bus.cmd_len != '0);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state <= StIdle;
            r_ready <= 1'b0;
            r_enb   <= 1'b0;
            r_addrb <= '0;
            r_k     <= '0;
            r_len   <= '0;
            r_seq   <= '0;
            r_dec   <= 1'b0;
            r_sel   <= '0;
            r_lk0   <= 1'b0;
        end else if (w_load) begin
            r_state <= StIssue;
            r_ready <= (bus.cmd_len == SEQ_CNT_DW'(1));
            r_enb   <= 1'b1;
            r_addrb <= bus.cmd_base_addr;
            r_k     <= '0;
            r_len   <= bus.cmd_len;
            r_seq   <= bus.cmd_seq_start;
            r_dec   <= bus.cmd_addr_dec;
            r_sel   <= bus.cmd_sel;
            r_lk0   <= bus.cmd_l_k_0;
        end else if (r_state == StIdle || w_last) begin
            // TB_addrb deliberately keeps the last issued row.
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_enb   <= 1'b0;
        end else begin
            r_k     <= w_k_nxt;
            r_addrb <= r_dec ? r_addrb - TB_AW'(1) : r_addrb + TB_AW'(1);
            r_seq   <= r_seq + SEQ_CNT_DW'(1);
            r_ready <= (w_k_nxt == r_len - SEQ_CNT_DW'(1));
        end
    end

    always_comb begin
        w_pipe_d = '0;
        if (r_state == StIssue) begin
            w_pipe_d = {1'b1, w_last, r_sel, r_lk0, r_seq};
        end
    end

    tb_rd_align_shreg #(
        .DW    (PipeDw),
        .DEPTH (RD_LAT)
    ) u_align (
        .i_clk       (clk),
        .i_clr       (sys_rst),
        .i_d         (w_pipe_d),
        .o_q         (w_pipe_q),
        .o_valid_any (w_pipe_any)
    );

    assign bus.cmd_ready    = r_ready;
    assign bus.TB_enb       = r_enb;
    assign bus.TB_addrb     = r_addrb;
    assign bus.done         = w_pipe_q[PipeDw-1] & w_pipe_q[PipeDw-2];
    assign bus.TB_doutb_sel = w_pipe_q[SEQ_CNT_DW+1 +: TB_DOUTB_SEL_DW];
    assign bus.l_k_0        = w_pipe_q[SEQ_CNT_DW];
    assign bus.seq_cnt_out  = w_pipe_q[SEQ_CNT_DW-1:0];
    assign bus.busy         = (r_state == StIssue) | w_pipe_any;

endmodule

// File: tb/tb_tb_portb_rd_ctrl.sv
// Bench for tb_portb_rd_ctrl: directed and random commands against a per-cycle
// expected-output timeline built from the command semantics.
module tb_tb_portb_rd_ctrl;
    import tb_portb_rd_ctrl_pkg::*;

    localparam int unsigned AW  = 10;
    localparam int unsigned SW  = 5;
    localparam int unsigned DW  = 5;
    localparam int unsigned LAT = 2;
    localparam int          N   = 4096;

    logic clk = 1'b0;
    logic sys_rst;
    always #5 clk = ~clk;

    tb_portb_rd_ctrl_if #(.TB_AW(AW), .SEQ_CNT_DW(SW), .TB_DOUTB_SEL_DW(DW)) bus ();

    tb_portb_rd_ctrl #(
        .TB_AW           (AW),
        .SEQ_CNT_DW      (SW),
        .TB_DOUTB_SEL_DW (DW),
        .RD_LAT          (LAT)
    ) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // Expected value of each output on each cycle.
    bit          exp_enb  [N];
    bit [AW-1:0] exp_addr [N];
    bit [DW-1:0] exp_sel  [N];
    bit          exp_lk   [N];
    bit [SW-1:0] exp_seq  [N];
    bit          exp_done [N];
    bit          exp_busy [N];

    int cyc        = 0;
    int last_issue = -100;
    int last_rst   = -100;
    int n_vec      = 0;
    int n_miss     = 0;
    bit accepted;

    function automatic bit model_ready(int t);
        return (t >= last_issue) && (t >= last_rst + 2);
    endfunction

    task automatic model_reset(int r);
        last_rst   = r;
        last_issue = -100;
        for (int t = r + 1; t < N; t++) begin
            exp_enb[t]  = 0; exp_addr[t] = '0; exp_sel[t]  = '0; exp_lk[t] = 0;
            exp_seq[t]  = '0; exp_done[t] = 0; exp_busy[t] = 0;
        end
    endtask

    task automatic model_accept(int c, int len, int base, int dec, int sel, int lk, int seq0);
        int t;
        int a;
        int addr;
        if (len == 0) return;
        addr = base;
        for (int k = 0; k < len; k++) begin
            t    = c + 1 + k;
            addr = (dec != 0) ? ((base - k) & ((1 << AW) - 1)) : ((base + k) & ((1 << AW) - 1));
            exp_enb[t]  = 1;
            exp_addr[t] = AW'(addr);
            for (int j = 0; j <= int'(LAT); j++) exp_busy[t + j] = 1;
            a = t + LAT;
            exp_sel[a]  = DW'(sel);
            exp_lk[a]   = lk[0];
            exp_seq[a]  = SW'((seq0 + k) & ((1 << SW) - 1));
            exp_done[a] = (k == len - 1);
        end
        last_issue = c + len;
        for (int u = c + len + 1; u < N; u++) exp_addr[u] = AW'(addr);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        chk("cmd_ready",    32'(bus.cmd_ready),    32'(model_ready(cyc)));
        chk("TB_enb",       32'(bus.TB_enb),       32'(exp_enb[cyc]));
        chk("TB_addrb",     32'(bus.TB_addrb),     32'(exp_addr[cyc]));
        chk("TB_doutb_sel", 32'(bus.TB_doutb_sel), 32'(exp_sel[cyc]));
        chk("l_k_0",        32'(bus.l_k_0),        32'(exp_lk[cyc]));
        chk("seq_cnt_out",  32'(bus.seq_cnt_out),  32'(exp_seq[cyc]));
        chk("done",         32'(bus.done),         32'(exp_done[cyc]));
        chk("busy",         32'(bus.busy),         32'(exp_busy[cyc]));
    endtask

    task automatic tick();
        accepted = 0;
        if (sys_rst) begin
            model_reset(cyc);
        end else if (bus.cmd_valid && model_ready(cyc)) begin
            accepted = 1;
            model_accept(cyc, int'(bus.cmd_len), int'(bus.cmd_base_addr),
                         int'(bus.cmd_addr_dec), int'(bus.cmd_sel), int'(bus.cmd_l_k_0),
                         int'(bus.cmd_seq_start));
        end
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic scramble();
        bus.cmd_sel       = DW'($urandom);
        bus.cmd_l_k_0     = 1'($urandom);
        bus.cmd_base_addr = AW'($urandom);
        bus.cmd_addr_dec  = 1'($urandom);
        bus.cmd_len       = SW'($urandom);
        bus.cmd_seq_start = SW'($urandom);
    endtask

    task automatic offer(int len, int base, int dec, int sel, int lk, int seq0);
        int guard;
        bus.cmd_len       = SW'(len);
        bus.cmd_base_addr = AW'(base);
        bus.cmd_addr_dec  = dec[0];
        bus.cmd_sel       = DW'(sel);
        bus.cmd_l_k_0     = lk[0];
        bus.cmd_seq_start = SW'(seq0);
        bus.cmd_valid     = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!accepted && guard < 64);
        if (!accepted) begin
            n_vec++;
            n_miss++;
            $error("FAIL offer_timeout cyc=%0d observed=not_accepted expected=accepted", cyc);
        end
        bus.cmd_valid = 1'b0;
        scramble();
    endtask

    task automatic drain(int n);
        repeat (n) tick();
    endtask

    initial begin
        sys_rst       = 1'b1;
        bus.cmd_valid = 1'b0;
        scramble();

        // Reset hold and release.
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();
        tick();

        offer(4, 'h010, 0, 5'b00101, 0, 0);
        drain(8);

        offer(7, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)),
              int'(tbb_sel(TBb_cov_HT_transpose, DIR_IDLE)), 1, 4);
        drain(10);

        // Back-to-back: B waits on A's last issue row.
        offer(3, 'h020, 0, int'(tbb_sel(TBb_B, DIR_POS)), 0, 7);
        offer(2, 'h005, 1, int'(tbb_sel(TBb_H_lv_H_transpose, DIR_NEG)), 1, 12);
        drain(8);

        // Address and sequence wrap, then a zero-length command.
        offer(4, 'h3FE, 0, int'(tbb_sel(TBb_B_cache_inv, DIR_NEW)), 0, 30);
        drain(8);
        offer(0, 'h111, 0, 5'b11111, 1, 3);
        drain(5);

        // Reset during the second issue row of a long command.
        offer(8, 'h100, 1, int'(tbb_sel(TBb_B, DIR_NEG)), 1, 2);
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        offer(3, 'h0F0, 0, int'(tbb_sel(TBb_B_cache_IDLE, DIR_POS)), 1, 9);
        drain(8);

        for (int i = 0; i < 30; i++) begin
            offer(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 31)));
            drain(int'($urandom_range(0, 3)));
        end
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
